// File: rtl/loop_stack.sv
// Loop-start address LIFO for the bracket sequencer.
// Top entry and status are registered; mem holds every live entry.
module loop_stack #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      top,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] D_ZERO = '0;
  localparam logic [DEPTH_LOG2:0] D_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] D_MAX  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] P_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] P_TWO = DEPTH_LOG2'(2);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr;
  logic [DEPTH_LOG2-1:0] wa;
  logic                  we;
  logic [WIDTH-1:0]      top_n;
  logic [DEPTH_LOG2:0]   depth_n;
  logic                  ovf_n;
  logic                  unf_n;
  logic                  empty_n;
  logic                  full_n;

  // Next free slot; wraps to 0 when full, which is never written then.
  assign ptr = depth[DEPTH_LOG2-1:0];

  // Decode push/pop into next state and the single mem write.
  always_comb begin
    top_n   = top;
    depth_n = depth;
    ovf_n   = overflow;
    unf_n   = underflow;
    we      = 1'b0;
    wa      = ptr;
    if (ce) begin
      unique case (1'b1)
        (push && !pop): begin
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            we      = 1'b1;
            wa      = ptr;
            depth_n = depth + D_ONE;
            top_n   = d;
          end
        end
        (!push && pop): begin
          if (empty) begin
            unf_n = 1'b1;
          end else if (depth == D_ONE) begin
            depth_n = D_ZERO;
            top_n   = '0;
          end else begin
            depth_n = depth - D_ONE;
            top_n   = mem[ptr - P_TWO];
          end
        end
        (push && pop): begin
          we    = 1'b1;
          top_n = d;
          if (empty) begin
            wa      = ptr;
            depth_n = D_ONE;
          end else begin
            wa = ptr - P_ONE;
          end
        end
        default: ;
      endcase
    end
    empty_n = (depth_n == D_ZERO);
    full_n  = (depth_n == D_MAX);
  end

  // Register top, depth and status flags together.
  always_ff @(posedge clk) begin
    if (reset) begin
      top       <= '0;
      depth     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top       <= top_n;
      depth     <= depth_n;
      empty     <= empty_n;
      full      <= full_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
    end
  end

  // Entry storage; contents survive reset but are unreachable.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem[wa] <= d;
    end
  end

endmodule
